// File: rtl/act_unit_if.sv
// Stream bundle between the accumulator, the activation stage and the next layer's buffer.
// The master modport is the environment side; the slave modport is the activation unit.
interface act_unit_if #(
    parameter int W     = 18,
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [LANES*W-1:0] in_data;
    logic [1:0]         in_mode;
    logic [W-1:0]       in_clip;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, in_clip, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_clip, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/act_unit.sv
// Multi-lane activation stage: capture stage A, activation computed into result stage B,
// full valid/ready back-pressure, and a saturating count of clipped lanes delivered.
module act_unit #(
    parameter int W          = 18,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    act_unit_if.slave        bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] clip_cnt
);
    localparam int SUM_W = CNT_W + $clog2(LANES + 1);

    logic               a_valid_q, a_valid_d;
    logic [LANES*W-1:0] a_data_q, a_data_d;
    logic [1:0]         a_mode_q, a_mode_d;
    logic [W-1:0]       a_clip_q, a_clip_d;
    logic               b_valid_q, b_valid_d;
    logic [LANES*W-1:0] b_data_q, b_data_d;
    logic [LANES-1:0]   b_flags_q, b_flags_d;
    logic [CNT_W-1:0]   clip_cnt_q, clip_cnt_d;

    logic               advance_b_s;
    logic               in_ready_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic [LANES*W-1:0] res_data_s;
    logic [LANES-1:0]   res_flags_s;
    logic [SUM_W-1:0]   cnt_sum_s;

    // Returns {clipped_flag, y} for one lane.
    function automatic logic [W:0] act_lane(input logic signed [W-1:0] x,
                                            input logic [1:0]          mode,
                                            input logic signed [W-1:0] clip);
        logic signed [W-1:0] ceil_v;
        logic signed [W-1:0] leak_v;
        logic [W:0]          r;
        ceil_v = clip[W-1] ? {W{1'b0}} : clip;
        leak_v = x >>> LEAK_SHIFT;
        case (mode)
            2'd0: r = {1'b0, x};
            2'd1: r = x[W-1] ? {1'b0, {W{1'b0}}} : {1'b0, x};
            2'd2: r = x[W-1] ? {1'b0, leak_v} : {1'b0, x};
            2'd3: begin
                if (x[W-1]) begin
                    r = {1'b0, {W{1'b0}}};
                end else if (x > ceil_v) begin
                    r = {1'b1, ceil_v};
                end else begin
                    r = {1'b0, x};
                end
            end
            default: r = {1'b0, x};
        endcase
        return r;
    endfunction

    function automatic logic [SUM_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [SUM_W-1:0] n;
        n = {SUM_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + {{(SUM_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Handshake qualifiers; in_ready is held low while reset is asserted.
    always_comb begin
        advance_b_s = !b_valid_q || bus.out_ready;
        in_ready_s  = rst_n && (!a_valid_q || advance_b_s);
        in_fire_s   = bus.in_valid && in_ready_s;
        out_fire_s  = b_valid_q && bus.out_ready;
    end

    // Per-lane activation of the beat held in stage A.
    always_comb begin
        logic [W:0] lane_r;
        lane_r      = {(W+1){1'b0}};
        res_data_s  = {(LANES*W){1'b0}};
        res_flags_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            lane_r                 = act_lane(a_data_q[i*W +: W], a_mode_q, a_clip_q);
            res_data_s[i*W +: W]   = lane_r[W-1:0];
            res_flags_s[i]         = lane_r[W];
        end
    end

    // Stage A loads on input handshake, otherwise empties when stage B takes its beat.
    always_comb begin
        a_data_d  = a_data_q;
        a_mode_d  = a_mode_q;
        a_clip_d  = a_clip_q;
        a_valid_d = a_valid_q;
        if (in_fire_s) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.in_data;
            a_mode_d  = bus.in_mode;
            a_clip_d  = bus.in_clip;
        end else if (advance_b_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
    end

    // Stage B takes the activated beat whenever it is empty or being consumed; it holds while stalled.
    always_comb begin
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        b_flags_d = b_flags_q;
        if (advance_b_s) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                b_data_d  = res_data_s;
                b_flags_d = res_flags_s;
            end else begin
                b_flags_d = {LANES{1'b0}};
            end
        end else begin
            b_valid_d = b_valid_q;
        end
    end

    // Clip counter: clear wins over a concurrent increment, and the sum saturates rather than wraps.
    always_comb begin
        cnt_sum_s  = {{(SUM_W-CNT_W){1'b0}}, clip_cnt_q} + popcount(b_flags_q);
        clip_cnt_d = clip_cnt_q;
        if (clr_cnt) begin
            clip_cnt_d = {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (cnt_sum_s > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) begin
                clip_cnt_d = {CNT_W{1'b1}};
            end else begin
                clip_cnt_d = cnt_sum_s[CNT_W-1:0];
            end
        end else begin
            clip_cnt_d = clip_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_q  <= 1'b0;
            a_data_q   <= {(LANES*W){1'b0}};
            a_mode_q   <= 2'd0;
            a_clip_q   <= {W{1'b0}};
            b_valid_q  <= 1'b0;
            b_data_q   <= {(LANES*W){1'b0}};
            b_flags_q  <= {LANES{1'b0}};
            clip_cnt_q <= {CNT_W{1'b0}};
        end else begin
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            a_mode_q   <= a_mode_d;
            a_clip_q   <= a_clip_d;
            b_valid_q  <= b_valid_d;
            b_data_q   <= b_data_d;
            b_flags_q  <= b_flags_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = b_valid_q;
    assign bus.out_data  = b_data_q;
    assign clip_cnt      = clip_cnt_q;
endmodule

// File: tb/tb_act_unit.sv
// Scoreboard bench for act_unit: expected beats are queued at input handshake and
// compared at output handshake; ready, hold-while-stalled and the clip counter are checked every cycle.
module tb_act_unit;
    localparam int W  = 18;
    localparam int L  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [L*W-1:0] data;
        int             nclip;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          clr_cnt;
    logic [CW-1:0] clip_cnt;
    logic          rdy_rand;
    logic          rdy_val;

    exp_t           sb[$];
    int             occ;
    int             model_cnt;
    logic           prev_stall;
    logic [L*W-1:0] prev_data;
    int             n_chk;
    int             n_fail;

    act_unit_if #(.W(W), .LANES(L)) bus ();

    act_unit #(.W(W), .LANES(L), .LEAK_SHIFT(3), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .clr_cnt  (clr_cnt),
        .clip_cnt (clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: random during the stress stream, otherwise the directed value.
    always @(posedge clk) begin
        #2;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [L*W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [L*W-1:0] r;
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < L; i++) r[i*W +: W] = v[i][W-1:0];
        return r;
    endfunction

    // Reference activation in integer arithmetic; leaky shift is floor(x/8).
    function automatic exp_t model(input logic [L*W-1:0] d, input logic [1:0] m, input logic [W-1:0] clip);
        exp_t r;
        int x, c, y;
        r.nclip = 0;
        r.data  = '0;
        c = int'($signed(clip));
        if (c < 0) c = 0;
        for (int i = 0; i < L; i++) begin
            x = int'($signed(d[i*W +: W]));
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (x < 0) ? -((-x + 7) / 8) : x;
                default: begin
                    if (x < 0) y = 0;
                    else if (x > c) begin y = c; r.nclip++; end
                    else y = x;
                end
            endcase
            r.data[i*W +: W] = y[W-1:0];
        end
        return r;
    endfunction

    // Cycle monitor: sampled on the falling edge, so it sees what the next rising edge will act on.
    always @(negedge clk) begin
        exp_t e;
        int   nflags;
        nflags = 0;
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 1'b0);
            sb.delete();
            occ        = 0;
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
            chk("clip_cnt", clip_cnt, model_cnt);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", bus.out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    nflags = e.nclip;
                end
                occ--;
            end
            if (clr_cnt) model_cnt = 0;
            else if (bus.out_valid && bus.out_ready)
                model_cnt = (model_cnt + nflags > CMAX) ? CMAX : model_cnt + nflags;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(model(bus.in_data, bus.in_mode, bus.in_clip));
                occ++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 of the accepting edge so beats can go back to back.
    task automatic send_beat(input logic [L*W-1:0] d, input logic [1:0] m, input int clip);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_clip  = clip[W-1:0];
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || occ != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_latency();
        @(negedge clk);
        chk("lat_edge1", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("lat_edge2", bus.out_valid, 1'b1);
    endtask

    initial begin
        int n;
        n_chk = 0; n_fail = 0; occ = 0; model_cnt = 0; prev_stall = 1'b0; prev_data = '0;
        rst_n = 1'b0; clr_cnt = 1'b0; rdy_rand = 1'b0; rdy_val = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 2'd0; bus.in_clip = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_clip_cnt", clip_cnt, '0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.in_ready, 1'b1);

        // ReLU with latency check
        sync();
        send_beat(pack4(-5, 0, 7, -131072), 2'd1, 0);
        check_latency();
        wait_drain();
        chk("relu_cnt", clip_cnt, '0);

        // Leaky then bypass, back to back
        sync();
        send_beat(pack4(-8, -1, -9, 100), 2'd2, 0);
        send_beat(pack4(-8, -1, -9, 100), 2'd0, 0);
        wait_drain();

        // Clipped ReLU: two lanes above the ceiling
        sync();
        send_beat(pack4(65, 64, -3, 131071), 2'd3, 64);
        wait_drain();
        chk("clip64_cnt", clip_cnt, 4'd2);
        sync();
        send_beat(pack4(5, -3, 1, 0), 2'd3, -10);
        wait_drain();
        chk("clipneg_cnt", clip_cnt, 4'd4);

        // Plain clear
        sync();
        clr_cnt = 1'b1;
        sync();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_cnt", clip_cnt, '0);

        // Saturation: 20 clipped lanes into a 4-bit counter
        sync();
        for (int i = 0; i < 5; i++) send_beat(pack4(100, 100, 100, 100), 2'd3, 0);
        wait_drain();
        chk("sat_cnt", clip_cnt, 4'd15);

        // Clear concurrent with a clipping output handshake
        rdy_val = 1'b0;
        sync();
        send_beat(pack4(100, 100, 100, 100), 2'd3, 0);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("stall_timeout", bus.out_valid, 1'b1);
        sync();
        clr_cnt = 1'b1;
        rdy_val = 1'b1;
        sync();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_vs_inc", clip_cnt, '0);
        wait_drain();

        // Random back-pressure stream with alternating modes
        rdy_rand = 1'b1;
        sync();
        for (int i = 0; i < 10; i++) begin
            send_beat({$urandom, $urandom, $urandom}, 2'(i % 4), $urandom_range(0, 300) - 100);
        end
        wait_drain();
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;

        // Reset with both stages full
        sync();
        send_beat(pack4(100, 100, 3, 100), 2'd3, 0);
        wait_drain();
        rdy_val = 1'b0;
        sync();
        send_beat(pack4(1, 2, 3, 4), 2'd0, 0);
        send_beat(pack4(200, -2, 3, 4), 2'd3, 50);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 1'b0);
        sync();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_data", bus.out_data, '0);
        chk("mid_rst_cnt", clip_cnt, '0);
        rdy_val = 1'b1;
        sync();
        send_beat(pack4(-7, 9, -131072, 131071), 2'd2, 0);
        check_latency();
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/act_unit.md
# act_unit

Parametrised, multi-lane activation stage placed between the neuron accumulator/adder and the next layer's input buffer. Applies one of four element-wise activation functions to LANES signed W-bit values per beat. Uses a two-stage valid/ready pipeline with full back-pressure. Keeps a saturating count of clipped lanes for range monitoring.

## Interface
- W, 18: signed data width per lane (>= 4)
- LANES, 4: lanes per beat (>= 1)
- LEAK_SHIFT, 3: arithmetic right-shift applied to negative inputs in leaky mode (1..W-1)
- CNT_W, 16: width of clip counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*W  lane i at [i*W +: W], two's complement
- in_mode  in  2  0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU; sampled with the beat
- in_clip  in  W  signed clip ceiling for mode 3; sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  LANES*W  activated lanes, same packing
- clr_cnt  in  1  synchronous clear of clip_cnt
- clip_cnt  out  CNT_W  saturating count of clipped lanes delivered

## Operation
- Pipeline: stage A holds the captured beat (data, mode, clip, a_valid). Stage B holds the result (out_data, out_valid). The function is computed combinationally from A into B.
- advance_b = !out_valid || out_ready. B loads from A when advance_b; out_valid <= a_valid on that edge.
- in_ready = !a_valid || advance_b (combinational). A loads on input handshake. Otherwise A empties when B takes it.
- Lane function on x, per beat mode:
  - mode 0: y = x.
  - mode 1: y = x[W-1] ? 0 : x.
  - mode 2: y = x[W-1] ? (x >>> LEAK_SHIFT) : x. Shift is floor (-1 -> -1, -8 -> -1 for shift 3).
  - mode 3: c = in_clip[W-1] ? 0 : in_clip. y = 0 if x < 0; y = c and lane flagged clipped if x > c; otherwise y = x. x == c is not clipped.
- Each lane computes independently. Mode and clip are per-beat; a mode change between consecutive beats takes effect with no bubble.
- clip_cnt increments by the popcount of clipped flags of the B beat on each output handshake. The count saturates at 2^CNT_W-1 (no wrap).
- clr_cnt has priority: a clear in the same cycle as an increment yields 0.
- Data in B is held stable while out_valid && !out_ready. In-flight beats are never dropped or duplicated.

## Timing
- Reset (rst_n low at edge): a_valid=0, out_valid=0, out_data=0, clip_cnt=0, stage-A data=0. in_ready reads 0 while rst_n is low and 1 in the first cycle after release.
- Reset mid-operation discards both stages in one edge. No output handshake completes on that edge.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+1 (2 registers, output visible in cycle N+1..N+2 window). Without stalls the result is consumed at edge N+2.
- Throughput: 1 beat/cycle with out_ready held high.
- Full back-pressure: with out_ready=0 and both stages full, in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational path out_ready -> in_ready).
- Simultaneous load/unload of A or B in one cycle is legal and preserves order.

## Test plan
- ReLU, W=18: lanes {-5, 0, 7, -131072} mode 1 -> {0, 0, 7, 0}. out_valid 2 edges after accept. clip_cnt stays 0.
- Leaky shift 3: {-8, -1, -9, 100} mode 2 -> {-1, -1, -2, 100}. Bypass mode 0 returns input unchanged.
- Clip: in_clip=64, lanes {65, 64, -3, 131071} mode 3 -> {64, 64, 0, 64}. clip_cnt +2. in_clip=-10 forces all outputs to 0 and flags positive lanes.
- Back-pressure: stream 10 beats with alternating modes, out_ready toggled randomly. Outputs in order, no loss or duplication, out_data stable while stalled, in_ready=0 when both stages full.
- Counter: CNT_W=4, drive 20 clipped lanes -> clip_cnt stops at 15. clr_cnt with a concurrent clipping handshake -> 0.
- Reset mid-stream with both stages full: next edge out_valid=0, out_data=0, clip_cnt=0. The first beat after release has latency 2.
